// File: rtl/stream_pkg.sv
// Shared definitions for the stream merger blocks.
//   MODE_RR / MODE_PRIO : arbitration mode selectors for stream_arbiter_fifo
//   clog2()             : ceiling log2, used to size index/pointer/count fields
package stream_pkg;

    localparam int MODE_RR   = 0;
    localparam int MODE_PRIO = 1;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Circular-buffer FIFO holding {source id, data} entries for the merger.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push/push_data write one entry at the tail
//   pop            remove the head entry (caller only pops when count != 0)
//   head_data      current head entry
//   count          occupancy, 0..DEPTH
// The caller never pushes into a full FIFO, so the tail never overwrites the
// head slot unless the FIFO is empty; head_data therefore only moves on a pop
// or on a push into an empty FIFO.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset; contents are meaningless while count == 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/stream_arbiter_fifo.sv
// N-to-1 merger of stb/ack word streams into one FIFO-buffered output stream.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   input_data      CHANNELS words, channel i at [i*WIDTH +: WIDTH]
//   input_stb       per-channel word valid
//   input_ack       registered one-cycle capture pulse, at most one bit high
//   channel_enable  a disabled channel is never granted
//   output_data/id  FIFO head word and its source channel
//   output_stb      FIFO non-empty
//   output_ack      consumer accept
//   fifo_count      FIFO occupancy
// Handshake: a producer raises stb with data and holds both until it sees ack;
// the word is captured in the cycle ack is high. On the output side a word is
// transferred in every cycle where output_stb && output_ack.
// A grant chosen in cycle N becomes input_ack in N+1, and the word is written
// to the FIFO in N+1. The space check in N therefore counts the push and pop
// already happening in N, so every issued ack has a reserved slot.
module stream_arbiter_fifo
    import stream_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int MODE     = 0,
    localparam int ID_WIDTH = clog2(CHANNELS),
    localparam int CNT_W    = clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] input_data,
    input  logic [CHANNELS-1:0]       input_stb,
    output logic [CHANNELS-1:0]       input_ack,
    input  logic [CHANNELS-1:0]       channel_enable,
    output logic [WIDTH-1:0]          output_data,
    output logic [ID_WIDTH-1:0]       output_id,
    output logic                      output_stb,
    input  logic                      output_ack,
    output logic [CNT_W-1:0]          fifo_count
);

    logic [CHANNELS-1:0] eligible;
    logic [ID_WIDTH-1:0] last_grant;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [ID_WIDTH-1:0] cand;
    logic                grant_valid;
    logic                space_ok;
    logic                push;
    logic                pop;
    logic [ID_WIDTH-1:0] ack_idx;
    logic [WIDTH-1:0]    ack_data;

    // A channel acked this cycle is masked: its producer is still holding stb
    // until the capture edge, and must not be granted a second time.
    assign eligible = input_stb & channel_enable & ~input_ack;
    assign push     = |input_ack;
    assign pop      = output_stb & output_ack;
    assign space_ok = (int'(fifo_count) + int'(push) - int'(pop)) < DEPTH;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (MODE == MODE_RR) begin
            // Walk backwards from the farthest candidate so the nearest
            // eligible channel after last_grant is the final assignment.
            for (int k = CHANNELS; k >= 1; k--) begin
                cand = ID_WIDTH'((int'(last_grant) + k) % CHANNELS);
                if (eligible[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = ID_WIDTH'(i);
                end
            end
        end
    end

    // Select the word of the channel being acked (one-hot input_ack).
    always_comb begin
        ack_idx  = '0;
        ack_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (input_ack[i]) begin
                ack_idx  = ID_WIDTH'(i);
                ack_data = input_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // last_grant resets to the top channel so channel 0 is served first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            input_ack  <= '0;
            last_grant <= ID_WIDTH'(CHANNELS - 1);
        end else begin
            input_ack <= '0;
            if (grant_valid && space_ok) begin
                input_ack[grant_idx] <= 1'b1;
                last_grant           <= grant_idx;
            end
        end
    end

    stream_fifo #(
        .WIDTH (WIDTH + ID_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({ack_idx, ack_data}),
        .pop       (pop),
        .head_data ({output_id, output_data}),
        .count     (fifo_count)
    );

    assign output_stb = (fifo_count != '0);

endmodule
